riscv_i32_fetch_sequencer: RTL
==============================

# riscv_i32_fetch_sequencer

Sequences instruction fetch for the i32 pipeline. It owns the fetch PC and a 2-bit request tag, and presents one outstanding request to the instruction memory. It filters responses by tag so stale data after a restart is dropped, and holds each returned instruction for decode until the pipeline control asks for the next one or a replay. It sits between pipeline control/decode and the ifetch memory port.

## Interface
Parameters:
- RESET_PC, 32'h0: fetch PC loaded at reset.
- TIMEOUT_CYCLES, 255: request watchdog limit. Used only when the timeout feature is compiled in.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_action  in  2  0=none, 1=restart, 2=next, 3=replay.
- restart_pc  in  32  target PC for a restart.
- ifetch_req_valid  out  1  request presented.
- ifetch_req_address  out  32  fetch address; bit 0 is always 0.
- ifetch_req_tag  out  2  current tag.
- ifetch_req_sequential  out  1  address = previous address + 4.
- ifetch_req_flush_pipeline  out  1  first request after a restart.
- ifetch_resp_valid  in  1  response present.
- ifetch_resp_data  in  32  instruction word.
- ifetch_resp_error  in  1  fetch fault.
- ifetch_resp_tag  in  2  tag of the request being answered.
- fetch_data_valid  out  1  held instruction available to decode.
- fetch_data_pc  out  32  PC of the held instruction.
- fetch_data_data  out  32  held instruction; 0 on error.
- fetch_data_error  out  1  held instruction faulted.

## Operation
- State register: IDLE, REQ, HOLD. Reset values: state=IDLE, pc=RESET_PC, tag=0. All outputs are 0 at reset.
- Restart (fetch_action=1) in any state:
  - pc<=restart_pc with bit 0 cleared; tag<=tag+1 (mod 4); state<=REQ; flush_pending<=1.
  - Restart takes priority over a response or any other action in the same cycle.
- IDLE: no request is presented. Actions 0, 2 and 3 are ignored, and responses are discarded.
- REQ:
  - ifetch_req_valid=1, address=pc, tag=tag.
  - ifetch_req_flush_pipeline=flush_pending; flush_pending clears after the first REQ cycle.
  - ifetch_req_sequential=1 only when REQ was entered through "next".
  - A response with ifetch_resp_tag==tag captures data, error and pc, then state<=HOLD. If error=1, the captured data is 0.
  - A response with a mismatched tag is dropped silently.
  - Actions 2 and 3 are ignored in REQ.
- HOLD: fetch_data_valid=1 with the captured pc, data and error.
  - Action 2: pc<=pc+4, wrapping mod 2^32; state<=REQ.
  - Action 3: same pc; state<=REQ; sequential=0.
  - Action 0: remain in HOLD.
  - Responses are discarded.
- At most one request is outstanding at any time.

## Timing
- All ifetch_req_* and fetch_data_* outputs are driven from registers, with no combinational path from inputs.
- A matching response in cycle N gives fetch_data_valid in cycle N+1.
- Action 2 or 3 in HOLD at cycle M gives ifetch_req_valid in M+1. fetch_data_valid drops in M+1.
- A restart at cycle M gives a request with flush=1 in M+1. Any response in M+1 or later carrying the old tag is dropped.
- Peak throughput is one instruction per 2 cycles, when memory responds in the same cycle as the request.
- Reset asserted mid-request forces IDLE immediately. A later response is dropped because the state is IDLE.

## Configuration
- RISCV_I32_FETCH_TIMEOUT_EN, when defined:
  - A counter clears on entry to REQ and increments every REQ cycle.
  - On reaching TIMEOUT_CYCLES with no matching response: state<=HOLD, fetch_data_error=1, data=0, tag<=tag+1, so a late response is dropped.
  - A matching response in the same cycle as the timeout wins.
- When undefined: REQ waits indefinitely and the counter is not instantiated.

## Structure
- Package riscv_i32_fetch_pkg holds:
  - fetch_action constants (NONE/RESTART/NEXT/REPLAY)
  - the state enum
  - FETCH_TAG_WIDTH=2
- Sub-module riscv_i32_fetch_timeout_counter (clear, enable, expired outputs) is instantiated only under RISCV_I32_FETCH_TIMEOUT_EN.

## Test plan
- Reset, then restart to 0x1000; memory answers tag 1 next cycle with 0x00000013 → request at 0x1000 with flush=1 and tag=1; fetch_data_valid with pc=0x1000 and data=0x13 one cycle after the response.
- HOLD with action=2 three times → requests at 0x1004, 0x1008, 0x100C, each with sequential=1 and flush=0.
- Restart to 0x2000 while a request for 0x1000 is outstanding; old-tag response arrives 2 cycles later → that response is dropped; only 0x2000 data reaches decode, with a tag one greater than before.
- Response with error=1 → fetch_data_error=1 and data=0; action=3 re-requests the same pc with sequential=0.
- pc=0xFFFFFFFC with action=2 → request at 0x00000000.
- With RISCV_I32_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, no response → HOLD with error=1 after 8 REQ cycles; a response 2 cycles later is dropped.

Source files
------------

// File: rtl/riscv_i32_fetch_pkg.sv
`default_nettype none
// riscv_i32_fetch_pkg: shared fetch-action encodings, FSM state type and tag width.
// Revision 1.0
package riscv_i32_fetch_pkg;

  localparam int FETCH_TAG_WIDTH = 2;

  localparam logic [1:0] ACT_NONE    = 2'd0;
  localparam logic [1:0] ACT_RESTART = 2'd1;
  localparam logic [1:0] ACT_NEXT    = 2'd2;
  localparam logic [1:0] ACT_REPLAY  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_i32_fetch_timeout_counter.sv
`default_nettype none
// riscv_i32_fetch_timeout_counter: request watchdog, expired on the LIMIT-th enabled cycle.
// Revision 1.0
module riscv_i32_fetch_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th cycle so the FSM leaves REQ after exactly LIMIT cycles.
  assign expired = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/riscv_i32_fetch_sequencer.sv
`default_nettype none
// riscv_i32_fetch_sequencer: single-outstanding ifetch sequencer with tag-filtered responses.
// Optional watchdog via RISCV_I32_FETCH_TIMEOUT_EN. Revision 1.0
module riscv_i32_fetch_sequencer
  import riscv_i32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [1:0]                 fetch_action,
  input  logic [31:0]                restart_pc,
  output logic                       ifetch_req_valid,
  output logic [31:0]                ifetch_req_address,
  output logic [FETCH_TAG_WIDTH-1:0] ifetch_req_tag,
  output logic                       ifetch_req_sequential,
  output logic                       ifetch_req_flush_pipeline,
  input  logic                       ifetch_resp_valid,
  input  logic [31:0]                ifetch_resp_data,
  input  logic                       ifetch_resp_error,
  input  logic [FETCH_TAG_WIDTH-1:0] ifetch_resp_tag,
  output logic                       fetch_data_valid,
  output logic [31:0]                fetch_data_pc,
  output logic [31:0]                fetch_data_data,
  output logic                       fetch_data_error
);

  fetch_state_e               state;
  logic [31:0]                pc;
  logic [FETCH_TAG_WIDTH-1:0] tag;
  logic                       flush_pending;
  logic                       sequential;
  logic [31:0]                held_pc;
  logic [31:0]                held_data;
  logic                       held_error;

  logic resp_match;
  logic timeout_expired;

  assign resp_match = ifetch_resp_valid && (ifetch_resp_tag == tag);

`ifdef RISCV_I32_FETCH_TIMEOUT_EN
  logic timeout_clear;
  assign timeout_clear = (fetch_action == ACT_RESTART) ||
                         ((state == ST_HOLD) &&
                          ((fetch_action == ACT_NEXT) || (fetch_action == ACT_REPLAY)));

  riscv_i32_fetch_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timeout_clear),
    .enable (state == ST_REQ),
    .expired(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      tag           <= '0;
      flush_pending <= 1'b0;
      sequential    <= 1'b0;
      held_pc       <= '0;
      held_data     <= '0;
      held_error    <= 1'b0;
    end else if (fetch_action == ACT_RESTART) begin
      // Bumping the tag makes any response to the abandoned request mismatch.
      state         <= ST_REQ;
      pc            <= {restart_pc[31:1], 1'b0};
      tag           <= tag + 1'b1;
      flush_pending <= 1'b1;
      sequential    <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          flush_pending <= 1'b0;
          if (resp_match) begin
            state      <= ST_HOLD;
            held_pc    <= pc;
            held_data  <= ifetch_resp_error ? 32'h0 : ifetch_resp_data;
            held_error <= ifetch_resp_error;
          end else if (timeout_expired) begin
            state      <= ST_HOLD;
            held_pc    <= pc;
            held_data  <= 32'h0;
            held_error <= 1'b1;
            tag        <= tag + 1'b1;
          end
        end
        ST_HOLD: begin
          if (fetch_action == ACT_NEXT) begin
            state      <= ST_REQ;
            pc         <= pc + 32'd4;
            sequential <= 1'b1;
          end else if (fetch_action == ACT_REPLAY) begin
            state      <= ST_REQ;
            sequential <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ifetch_req_valid          = (state == ST_REQ);
  assign ifetch_req_address        = (state == ST_REQ) ? pc : 32'h0;
  assign ifetch_req_tag            = tag;
  assign ifetch_req_sequential     = (state == ST_REQ) && sequential;
  assign ifetch_req_flush_pipeline = (state == ST_REQ) && flush_pending;
  assign fetch_data_valid          = (state == ST_HOLD);
  assign fetch_data_pc             = held_pc;
  assign fetch_data_data           = held_data;
  assign fetch_data_error          = held_error;

endmodule
`default_nettype wire
